// File: rtl/qspi_read_sequencer.sv
// Quad-I/O fast-read sequencer: one 32-bit word per request.
// SCK runs at clk/2 in mode 0; cmd on io[0], then addr, dummy, data on io[3:0].
module qspi_read_sequencer #(
  parameter int unsigned ADDR_W       = 24,
  parameter logic [7:0]  CMD          = 8'hEB,
  parameter int unsigned DUMMY_CYCLES = 6,
  parameter int unsigned CS_GAP       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              busy,
  output logic              qspi_ck_o,
  output logic              qspi_cs_o,
  output logic [3:0]        qspi_io_o,
  input  logic [3:0]        qspi_io_i,
  output logic              qspi_io_t
);

  localparam int unsigned GAP_W =
    (CS_GAP < 2) ? 1 : $clog2(CS_GAP + 1);

  localparam logic [3:0] CMD_LAST   = 4'd7;
  localparam logic [3:0] ADDR_LAST  = 4'(ADDR_W / 4 - 1);
  localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_CYCLES - 1);
  localparam logic [3:0] DATA_LAST  = 4'd7;

  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(CS_GAP);
  localparam logic [GAP_W-1:0] GAP_DONE = GAP_W'(CS_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  state_t            nxt_state;
  logic              phase_q, phase_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        nxt_idx;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       sr_q, sr_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              cs_q, cs_d;
  logic              ck_q, ck_d;
  logic [3:0]        io_o_q, io_o_d;
  logic              io_t_q, io_t_d;
  logic              rv_q, rv_d;
  logic [31:0]       rdata_q, rdata_d;

  assign req_ready  = (state_q == S_IDLE) && (gap_q == '0);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = rv_q;
  assign resp_data  = rdata_q;
  assign qspi_ck_o  = ck_q;
  assign qspi_cs_o  = cs_q;
  assign qspi_io_o  = io_o_q;
  assign qspi_io_t  = io_t_q;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    sr_d      = sr_q;
    gap_d     = gap_q;
    cs_d      = cs_q;
    ck_d      = ck_q;
    io_o_d    = io_o_q;
    io_t_d    = io_t_q;
    rv_d      = 1'b0;
    rdata_d   = rdata_q;
    nxt_state = state_q;
    nxt_idx   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (gap_q != '0) gap_d = gap_q - GAP_ONE;
        if (req_valid && req_ready) begin
          state_d = S_CMD;
          idx_d   = CMD_LAST;
          phase_d = 1'b1;
          addr_d  = req_addr;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gap_d   = GAP_DONE;
      end
      default: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          ck_d    = 1'b1;
          if (state_q == S_DATA)
            sr_d = {sr_q[27:0], qspi_io_i};
        end else begin
          // cs still high means launch cycle: enter CMD bit 7 unchanged
          if (!cs_q) begin
            if (idx_q != '0) begin
              nxt_idx = idx_q - 4'd1;
            end else begin
              unique case (state_q)
                S_CMD: begin
                  nxt_state = S_ADDR;
                  nxt_idx   = ADDR_LAST;
                end
                S_ADDR: begin
                  nxt_state = S_DUMMY;
                  nxt_idx   = DUMMY_LAST;
                end
                S_DUMMY: begin
                  nxt_state = S_DATA;
                  nxt_idx   = DATA_LAST;
                end
                default: begin
                  nxt_state = S_DONE;
                  nxt_idx   = '0;
                end
              endcase
            end
          end
          state_d = nxt_state;
          idx_d   = nxt_idx;
          phase_d = 1'b0;
          ck_d    = 1'b0;
          if (nxt_state == S_DONE) begin
            cs_d    = 1'b1;
            io_t_d  = 1'b0;
            io_o_d  = '0;
            rv_d    = 1'b1;
            rdata_d = {sr_q[7:0], sr_q[15:8],
                       sr_q[23:16], sr_q[31:24]};
          end else begin
            cs_d = 1'b0;
            unique case (nxt_state)
              S_CMD: begin
                io_t_d = 1'b1;
                io_o_d = {3'b000, CMD[nxt_idx[2:0]]};
              end
              S_ADDR: begin
                io_t_d = 1'b1;
                io_o_d = addr_q[ADDR_W-1 -: 4];
                addr_d = addr_q << 4;
              end
              default: begin
                io_t_d = 1'b0;
                io_o_d = '0;
              end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      idx_q   <= '0;
      addr_q  <= '0;
      sr_q    <= '0;
      gap_q   <= GAP_INIT;
      cs_q    <= 1'b1;
      ck_q    <= 1'b0;
      io_o_q  <= '0;
      io_t_q  <= 1'b0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      sr_q    <= sr_d;
      gap_q   <= gap_d;
      cs_q    <= cs_d;
      ck_q    <= ck_d;
      io_o_q  <= io_o_d;
      io_t_q  <= io_t_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_qspi_read_sequencer.sv
// Bench for qspi_read_sequencer: flash model on the pads plus a
// cycle-level protocol model compared against the outputs every cycle.
module tb_qspi_read_sequencer;

  localparam int ADDR_W = 24;
  localparam int DUMMY  = 6;
  localparam int CS_GAP = 2;
  localparam int AN     = ADDR_W / 4;
  localparam int TOT    = 8 + AN + DUMMY + 8;
  localparam int LAT    = 2 * TOT + 1;
  localparam logic [7:0] CMD = 8'hEB;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              req_ready;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              busy;
  logic              ck;
  logic              cs;
  logic [3:0]        io_o;
  logic [3:0]        io_i = 4'h0;
  logic              io_t;

  always #5 clk = ~clk;

  qspi_read_sequencer #(
    .ADDR_W(ADDR_W),
    .CMD(CMD),
    .DUMMY_CYCLES(DUMMY),
    .CS_GAP(CS_GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .busy(busy),
    .qspi_ck_o(ck),
    .qspi_cs_o(cs),
    .qspi_io_o(io_o),
    .qspi_io_i(io_i),
    .qspi_io_t(io_t)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] mem [0:1023];
  logic [7:0] cmd_v = CMD;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++)
      w[8*i +: 8] = mem[10'((int'(a[9:0]) + i) % 1024)];
    return w;
  endfunction

  // flash device: counts SCK rises while selected, decodes cmd/addr,
  // drives 4'hF in dummy and the addressed bytes in data
  int fl_n = 0, fl_t1 = 0, fl_hi = 0;
  int fl_last_n = 0, fl_last_t1 = 0, fl_last_hi = 0;
  bit fl_act = 0, fl_prev_ck = 0;
  logic [7:0] fl_cmd = '0, fl_last_cmd = '0;
  logic [ADDR_W-1:0] fl_addr = '0, fl_last_addr = '0;

  always @(negedge clk) begin
    int k;
    logic [7:0] b;
    if (cs) begin
      if (fl_act) begin
        fl_last_n    = fl_n;
        fl_last_t1   = fl_t1;
        fl_last_cmd  = fl_cmd;
        fl_last_addr = fl_addr;
        fl_hi        = 0;
      end
      fl_act = 0;
      fl_n   = 0;
      fl_t1  = 0;
      fl_hi++;
      io_i = 4'($urandom);
    end else begin
      if (!fl_act) fl_last_hi = fl_hi;
      fl_act = 1;
      if (ck && !fl_prev_ck) begin
        if (fl_n < 8)
          fl_cmd = {fl_cmd[6:0], io_o[0]};
        else if (fl_n < 8 + AN)
          fl_addr = {fl_addr[ADDR_W-5:0], io_o};
        if (io_t) fl_t1++;
        fl_n++;
      end
      if (fl_n >= 8 + AN && fl_n < 8 + AN + DUMMY) begin
        io_i = 4'hF;
      end else if (fl_n >= 8 + AN + DUMMY && fl_n < TOT) begin
        k = fl_n - (8 + AN + DUMMY);
        b = mem[10'((int'(fl_addr[9:0]) + k / 2) % 1024)];
        io_i = (k % 2 == 0) ? b[7:4] : b[3:0];
      end else begin
        io_i = 4'($urandom);
      end
    end
    fl_prev_ck = ck;
  end

  // protocol model: outputs derived from offset since the accept edge
  bit model_on = 0;
  bit pending = 0;
  int acc = 0;
  int free_c = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [31:0] m_rdata = '0;

  always @(negedge clk) begin
    int off, s;
    logic e_cs, e_ck, e_t, e_rv, e_rdy;
    logic [3:0] e_io;
    e_rdy = 1'b0;
    if (model_on) begin
      off  = cyc - acc;
      e_cs = 1'b1;
      e_ck = 1'b0;
      e_t  = 1'b0;
      e_rv = 1'b0;
      e_io = '0;
      e_rdy = !pending && (cyc - free_c >= CS_GAP);
      if (pending) begin
        if (off >= 1 && off <= 2 * TOT) e_cs = 1'b0;
        if (off >= 2 && off <= 2 * TOT && off % 2 == 0) e_ck = 1'b1;
        if (off >= 1 && off <= 2 * (8 + AN)) begin
          e_t = 1'b1;
          s = (off - 1) / 2;
          if (s < 8) e_io = {3'b000, cmd_v[7 - s]};
          else e_io = m_addr[4 * (AN - 1 - (s - 8)) +: 4];
        end
        if (off == LAT) begin
          e_rv = 1'b1;
          m_rdata = word_at(m_addr);
        end
      end
      chk("cs_o", 32'(cs), 32'(e_cs));
      chk("ck_o", 32'(ck), 32'(e_ck));
      chk("io_t", 32'(io_t), 32'(e_t));
      if (e_t) chk("io_o", 32'(io_o), 32'(e_io));
      chk("busy", 32'(busy), 32'(pending));
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("resp_valid", 32'(resp_valid), 32'(e_rv));
      chk("resp_data", resp_data, m_rdata);
      if (pending && off == LAT) begin
        pending = 0;
        free_c  = cyc;
      end
    end
    if (rst) begin
      model_on = 1;
      pending  = 0;
      free_c   = cyc + 1;
      m_rdata  = '0;
    end else if (model_on && e_rdy && req_valid) begin
      pending = 1;
      acc     = cyc + 1;
      m_addr  = req_addr;
    end
  end

  task automatic issue(input logic [ADDR_W-1:0] a, input bit keep,
                       output int acc_c);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(n), 32'(0));
      req_valid = 1'b0;
      acc_c = cyc;
      @(posedge clk);
      #1;
    end else begin
      @(posedge clk);
      #1;
      acc_c = cyc;
      if (!keep) req_valid = 1'b0;
    end
  endtask

  task automatic wait_resp(input int acc_c, output int lat);
    int n;
    n = 0;
    lat = -1;
    while (n < 200 && lat < 0) begin
      @(posedge clk);
      #1;
      n++;
      if (resp_valid) lat = cyc - acc_c;
    end
    if (lat < 0) chk("resp_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, lat, done1;
    logic [ADDR_W-1:0] ad;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[256] = 8'h11;
    mem[257] = 8'h22;
    mem[258] = 8'h33;
    mem[259] = 8'h44;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", 32'(cs), 1);
    chk("rst_ck", 32'(ck), 0);
    chk("rst_io_t", 32'(io_t), 0);
    chk("rst_io_o", 32'(io_o), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 0);
    rst = 1'b0;
    repeat (CS_GAP - 1) @(posedge clk);
    #1;
    chk("ready_early", 32'(req_ready), 0);
    @(posedge clk);
    #1;
    chk("ready_rise", 32'(req_ready), 1);

    issue(24'h000100, 1'b0, a1);
    wait_resp(a1, lat);
    chk("single_latency", 32'(lat), 57);
    chk("single_data", resp_data, 32'h44332211);
    @(negedge clk);
    #1;
    chk("sck_count", 32'(fl_last_n), 28);
    chk("cmd_bits", 32'(fl_last_cmd), 32'hEB);
    chk("flash_addr", 32'(fl_last_addr), 32'h000100);
    chk("drive_sck", 32'(fl_last_t1), 14);
    @(posedge clk);
    #1;

    issue(24'h000000, 1'b1, a1);
    req_addr = 24'h000004;
    wait_resp(a1, lat);
    chk("b2b_first", resp_data, word_at(24'h000000));
    done1 = cyc;
    issue(24'h000004, 1'b0, a2);
    chk("b2b_gap", 32'((a2 - done1) >= CS_GAP), 1);
    wait_resp(a2, lat);
    chk("b2b_second", resp_data, word_at(24'h000004));
    chk("b2b_cs_high", 32'(fl_last_hi >= 2), 1);

    ad = 24'($urandom);
    issue(ad, 1'b0, a1);
    repeat (49) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_cs", 32'(cs), 1);
    chk("abort_ck", 32'(ck), 0);
    chk("abort_rv", 32'(resp_valid), 0);
    repeat (70) @(posedge clk);
    #1;
    ad = 24'($urandom);
    issue(ad, 1'b0, a1);
    wait_resp(a1, lat);
    chk("after_abort", resp_data, word_at(ad));

    ad = 24'($urandom);
    issue(ad, 1'b0, a1);
    repeat (10) @(posedge clk);
    #1;
    req_valid = 1'b1;
    lat = 0;
    while (!resp_valid && lat < 100) begin
      req_addr = 24'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    chk("busy_ignore", resp_data, word_at(ad));
    ad = req_addr;
    issue(ad, 1'b0, a2);
    wait_resp(a2, lat);
    chk("busy_next", resp_data, word_at(ad));

    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      ad = 24'($urandom);
      issue(ad, 1'b0, a1);
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 55)) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end else begin
        wait_resp(a1, lat);
      end
    end

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
